// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operation encodings (also used by the
// control unit to drive MDUOpE), sequencer state encoding and default busy-cycle counts.
package mdu_pkg;

  typedef enum logic [3:0] {
    OpNone  = 4'd0,
    OpMult  = 4'd1,
    OpMultu = 4'd2,
    OpDiv   = 4'd3,
    OpDivu  = 4'd4,
    OpMthi  = 4'd5,
    OpMtlo  = 4'd6,
    OpMfhi  = 4'd7,
    OpMflo  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    StIdle = 1'b0,
    StRun  = 1'b1
  } mdu_state_e;

  localparam int unsigned MultCyclesDef = 5;
  localparam int unsigned DivCyclesDef  = 10;

endpackage

// File: rtl/mdu_ctrl_if.sv
// E-stage MDU bundle between the pipeline (master) and the MDU sequencer (slave).
//   MDUOpE/StartE/SrcA/SrcB : operation request from E stage
//   Busy/Start              : hazard-unit status
//   HI/LO/MDUOut            : architectural registers and mfhi/mflo read data
interface mdu_ctrl_if;
  import mdu_pkg::*;

  mdu_op_e     MDUOpE;
  logic        StartE;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic        Busy;
  logic        Start;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDUOut;

  modport master (
    output MDUOpE, StartE, SrcA, SrcB,
    input  Busy, Start, HI, LO, MDUOut
  );

  modport slave (
    input  MDUOpE, StartE, SrcA, SrcB,
    output Busy, Start, HI, LO, MDUOut
  );

endinterface

// File: rtl/mdu_arith.sv
// Combinational 64-bit multiply/divide result generator.
//   op_i          : operation code
//   src_a_i/b_i   : operands (rs, rt)
//   hi_res_o      : product high word, or remainder
//   lo_res_o      : product low word, or quotient
//   div_by_zero_o : div/divu with a zero divisor
module mdu_arith
  import mdu_pkg::*;
(
  input  mdu_op_e     op_i,
  input  logic [31:0] src_a_i,
  input  logic [31:0] src_b_i,
  output logic [31:0] hi_res_o,
  output logic [31:0] lo_res_o,
  output logic        div_by_zero_o
);

  logic        is_signed;
  logic [63:0] a_ext, b_ext, prod;
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, b_safe, q_mag, r_mag, quot, rem;

  always_comb begin
    is_signed = (op_i == OpMult) || (op_i == OpDiv);

    a_ext = is_signed ? {{32{src_a_i[31]}}, src_a_i} : {32'b0, src_a_i};
    b_ext = is_signed ? {{32{src_b_i[31]}}, src_b_i} : {32'b0, src_b_i};
    // Low 64 bits of the extended product are correct for both signednesses.
    prod  = a_ext * b_ext;

    // Divide on magnitudes, then fix signs: quotient truncates toward zero and
    // the remainder follows the dividend. 0x80000000 / -1 falls out as 0x80000000.
    a_neg  = is_signed & src_a_i[31];
    b_neg  = is_signed & src_b_i[31];
    a_mag  = a_neg ? (~src_a_i + 32'd1) : src_a_i;
    b_mag  = b_neg ? (~src_b_i + 32'd1) : src_b_i;
    b_safe = (b_mag == 32'd0) ? 32'd1 : b_mag;  // result discarded on divide by zero
    q_mag  = a_mag / b_safe;
    r_mag  = a_mag % b_safe;
    quot   = (a_neg ^ b_neg) ? (~q_mag + 32'd1) : q_mag;
    rem    = a_neg ? (~r_mag + 32'd1) : r_mag;

    hi_res_o      = 32'd0;
    lo_res_o      = 32'd0;
    div_by_zero_o = 1'b0;
    case (op_i)
      OpMult, OpMultu: begin
        hi_res_o = prod[63:32];
        lo_res_o = prod[31:0];
      end
      OpDiv, OpDivu: begin
        hi_res_o      = rem;
        lo_res_o      = quot;
        div_by_zero_o = (src_b_i == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer sitting beside the E-stage ALU. Owns HI/LO,
// runs mult/multu/div/divu for a fixed number of busy cycles and services mthi/mtlo/mfhi/mflo.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : mdu_ctrl_if slave (request in; Busy/Start/HI/LO/MDUOut out)
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MultCyclesDef,
  parameter int unsigned DIV_CYCLES  = DivCyclesDef
) (
  input logic       clk,
  input logic       rst,
  mdu_ctrl_if.slave bus
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = $clog2(MaxCycles + 1);

  mdu_state_e  state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [31:0] sh_hi_q, sh_hi_d, sh_lo_q, sh_lo_d;
  logic        sh_dz_q, sh_dz_d;

  logic        is_mul_op, is_div_op, accept, last_cycle;
  logic [31:0] hi_res, lo_res;
  logic        div_by_zero;

  mdu_arith u_arith (
    .op_i          (bus.MDUOpE),
    .src_a_i       (bus.SrcA),
    .src_b_i       (bus.SrcB),
    .hi_res_o      (hi_res),
    .lo_res_o      (lo_res),
    .div_by_zero_o (div_by_zero)
  );

  assign is_mul_op  = (bus.MDUOpE == OpMult) || (bus.MDUOpE == OpMultu);
  assign is_div_op  = (bus.MDUOpE == OpDiv) || (bus.MDUOpE == OpDivu);
  assign accept     = bus.StartE && (is_mul_op || is_div_op) && (state_q == StIdle);
  assign last_cycle = (state_q == StRun) && (cnt_q == CntW'(1));

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      sh_hi_q <= '0;
      sh_lo_q <= '0;
      sh_dz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      sh_hi_q <= sh_hi_d;
      sh_lo_q <= sh_lo_d;
      sh_dz_q <= sh_dz_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StRun;
      StRun:   if (last_cycle) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Counter, shadow and HI/LO next values
  always_comb begin
    cnt_d   = cnt_q;
    sh_hi_d = sh_hi_q;
    sh_lo_d = sh_lo_q;
    sh_dz_d = sh_dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == StIdle) begin
      if (accept) begin
        cnt_d   = is_mul_op ? CntW'(MULT_CYCLES) : CntW'(DIV_CYCLES);
        sh_hi_d = hi_res;
        sh_lo_d = lo_res;
        sh_dz_d = div_by_zero;
      end else if (bus.StartE) begin
        if (bus.MDUOpE == OpMthi) hi_d = bus.SrcA;
        if (bus.MDUOpE == OpMtlo) lo_d = bus.SrcA;
      end
    end else begin
      // Moves arriving while busy are dropped; only the completion writes HI/LO.
      cnt_d = cnt_q - CntW'(1);
      if (last_cycle && !sh_dz_q) begin
        hi_d = sh_hi_q;
        lo_d = sh_lo_q;
      end
    end
  end

  // Outputs
  always_comb begin
    bus.Start = accept;
    bus.Busy  = (state_q == StRun);
    bus.HI    = hi_q;
    bus.LO    = lo_q;
    case (bus.MDUOpE)
      OpMfhi:  bus.MDUOut = hi_q;
      OpMflo:  bus.MDUOut = lo_q;
      default: bus.MDUOut = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int MultN = 5;
  localparam int DivN  = 10;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk  = 0;
  int   n_fail = 0;

  // Architectural view of HI/LO as the model believes it
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  mdu_ctrl_if bus ();

  mdu_ctrl #(
    .MULT_CYCLES (MultN),
    .DIV_CYCLES  (DivN)
  ) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit s, input mdu_op_e op, input logic [31:0] a, input logic [31:0] b);
    bus.StartE = s;
    bus.MDUOpE = op;
    bus.SrcA   = a;
    bus.SrcB   = b;
  endtask

  // Reference results from plain 64-bit integer arithmetic
  function automatic void ref_calc(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] hi, output logic [31:0] lo, output bit dz);
    longint sa, sb, p, q, r;
    longint unsigned ua, ub, up, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    hi = 32'd0;
    lo = 32'd0;
    dz = 1'b0;
    case (op)
      OpMult:  begin p = sa * sb; hi = p[63:32]; lo = p[31:0]; end
      OpMultu: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
      OpDiv: begin
        if (b == 32'd0) dz = 1'b1;
        else begin q = sa / sb; r = sa % sb; lo = q[31:0]; hi = r[31:0]; end
      end
      OpDivu: begin
        if (b == 32'd0) dz = 1'b1;
        else begin uq = ua / ub; ur = ua % ub; lo = uq[31:0]; hi = ur[31:0]; end
      end
      default: ;
    endcase
  endfunction

  // Multi-cycle op; optionally inject another request at busy cycle inj_at (0-based)
  task automatic run_multi(input mdu_op_e op, input logic [31:0] a, input logic [31:0] b,
                           input int inj_at, input mdu_op_e inj_op, input logic [31:0] inj_a);
    logic [31:0] e_hi, e_lo;
    bit dz;
    int n;
    ref_calc(op, a, b, e_hi, e_lo, dz);
    n = (op == OpMult || op == OpMultu) ? MultN : DivN;
    drive(1'b1, op, a, b);
    #1;
    chk("start_accept", bus.Start, 32'd1);
    chk("busy_before", bus.Busy, 32'd0);
    step();
    drive(1'b0, OpNone, $urandom, $urandom);
    for (int i = 0; i < n; i++) begin
      if (i == inj_at) begin
        drive(1'b1, inj_op, inj_a, $urandom);
        #1;
        chk("start_while_busy", bus.Start, 32'd0);
        if (inj_op == OpMfhi) chk("mfhi_while_busy", bus.MDUOut, m_hi);
        if (inj_op == OpMflo) chk("mflo_while_busy", bus.MDUOut, m_lo);
      end else begin
        #1;
      end
      chk("busy_run", bus.Busy, 32'd1);
      chk("hi_hold", bus.HI, m_hi);
      chk("lo_hold", bus.LO, m_lo);
      step();
      drive(1'b0, OpNone, $urandom, $urandom);
    end
    #1;
    chk("busy_done", bus.Busy, 32'd0);
    if (!dz) begin
      m_hi = e_hi;
      m_lo = e_lo;
    end
    chk("hi_result", bus.HI, m_hi);
    chk("lo_result", bus.LO, m_lo);
  endtask

  // Single-cycle register move / read, or an idle request
  task automatic do_move(input bit s, input mdu_op_e op, input logic [31:0] a);
    drive(s, op, a, $urandom);
    #1;
    chk("move_start", bus.Start, 32'd0);
    chk("move_busy", bus.Busy, 32'd0);
    if (op == OpMfhi) chk("mfhi_out", bus.MDUOut, m_hi);
    else if (op == OpMflo) chk("mflo_out", bus.MDUOut, m_lo);
    else chk("mduout_zero", bus.MDUOut, 32'd0);
    step();
    drive(1'b0, OpNone, 32'd0, 32'd0);
    if (s && op == OpMthi) m_hi = a;
    if (s && op == OpMtlo) m_lo = a;
    #1;
    chk("move_busy_after", bus.Busy, 32'd0);
    chk("move_hi", bus.HI, m_hi);
    chk("move_lo", bus.LO, m_lo);
  endtask

  initial begin
    mdu_op_e op, iop;
    logic [31:0] a, b;
    int inj;

    rst_n = 1'b0;
    drive(1'b0, OpNone, 32'd0, 32'd0);
    repeat (3) step();
    chk("rst_busy", bus.Busy, 32'd0);
    chk("rst_hi", bus.HI, 32'd0);
    chk("rst_lo", bus.LO, 32'd0);
    chk("rst_start", bus.Start, 32'd0);
    rst_n = 1'b1;
    step();

    run_multi(OpMult, 32'hFFFF_FFFE, 32'd3, -1, OpNone, 32'd0);
    chk("plan_mult_hi", bus.HI, 32'hFFFF_FFFF);
    chk("plan_mult_lo", bus.LO, 32'hFFFF_FFFA);
    run_multi(OpMultu, 32'hFFFF_FFFE, 32'd3, -1, OpNone, 32'd0);
    chk("plan_multu_hi", bus.HI, 32'h0000_0002);
    chk("plan_multu_lo", bus.LO, 32'hFFFF_FFFA);
    run_multi(OpDiv, 32'hFFFF_FFF9, 32'd2, -1, OpNone, 32'd0);
    chk("plan_div_hi", bus.HI, 32'hFFFF_FFFF);
    chk("plan_div_lo", bus.LO, 32'hFFFF_FFFD);
    run_multi(OpDiv, 32'h8000_0000, 32'hFFFF_FFFF, -1, OpNone, 32'd0);
    chk("plan_divovf_hi", bus.HI, 32'd0);
    chk("plan_divovf_lo", bus.LO, 32'h8000_0000);

    do_move(1'b1, OpMthi, 32'd1);
    do_move(1'b1, OpMtlo, 32'd2);
    run_multi(OpDivu, 32'd7, 32'd0, -1, OpNone, 32'd0);
    chk("plan_divz_hi", bus.HI, 32'd1);
    chk("plan_divz_lo", bus.LO, 32'd2);

    do_move(1'b1, OpMthi, 32'h1234_5678);
    do_move(1'b1, OpMfhi, 32'd0);
    chk("plan_mfhi_hi", bus.HI, 32'h1234_5678);

    run_multi(OpDiv, 32'd100, 32'd7, 2, OpMtlo, 32'hDEAD_BEEF);
    chk("plan_mtlo_busy_lo", bus.LO, 32'd14);
    run_multi(OpDiv, 32'd1000, 32'd9, 3, OpMult, 32'd5);
    chk("plan_mid_start_lo", bus.LO, 32'd111);
    chk("plan_mid_start_hi", bus.HI, 32'd1);

    // Asynchronous reset in busy cycle 3 of a mult
    drive(1'b1, OpMult, 32'd6, 32'd7);
    step();
    drive(1'b0, OpNone, 32'd0, 32'd0);
    step();
    step();
    rst_n = 1'b0;
    #1;
    m_hi = 32'd0;
    m_lo = 32'd0;
    chk("midrst_busy", bus.Busy, 32'd0);
    chk("midrst_hi", bus.HI, 32'd0);
    chk("midrst_lo", bus.LO, 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < MultN + 3; i++) begin
      step();
      chk("postrst_busy", bus.Busy, 32'd0);
      chk("postrst_hi", bus.HI, 32'd0);
      chk("postrst_lo", bus.LO, 32'd0);
    end

    // Random mix against the model
    for (int k = 0; k < 60; k++) begin
      op = mdu_op_e'($urandom_range(0, 8));
      a  = $urandom;
      case ($urandom_range(0, 3))
        0:       b = 32'd0;
        1:       b = $urandom_range(1, 16);
        2:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if (op >= OpMult && op <= OpDivu) begin
        iop = mdu_op_e'($urandom_range(1, 8));
        inj = $urandom_range(0, 2) == 0 ? -1 : int'($urandom_range(0, MultN - 1));
        run_multi(op, a, b, inj, iop, $urandom);
      end else if (op == OpNone) begin
        // Valid-looking mult with StartE low must be ignored
        do_move(1'b0, OpNone, a);
        drive(1'b0, OpMult, a, b);
        #1;
        chk("nostart_start", bus.Start, 32'd0);
        step();
        #1;
        chk("nostart_busy", bus.Busy, 32'd0);
      end else begin
        do_move(1'b1, op, a);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Multi-cycle multiply/divide sequencer for the 5-stage pipeline; sits in E stage beside the ALU.
- Owns the HI/LO registers and sequences mult/multu/div/divu over a fixed cycle count.
- Exposes Busy and Start so the hazard unit can stall any D-stage MDU instruction while an operation is in flight.
- Also services mthi/mtlo writes and mfhi/mflo reads.

Parameters:
- MULT_CYCLES, 5, Busy cycles for mult/multu (>=1).
- DIV_CYCLES, 10, Busy cycles for div/divu (>=1).

Ports:
- clk  input  1  clock, rising-edge.
- rst  input  1  reset; asynchronous, active-low.
- MDUOpE  input  4  E-stage operation code (encodings in package).
- StartE  input  1  E-stage instruction is a valid MDU op. Pipeline drives 0 for bubbles.
- SrcA  input  32  forwarded rs value (RD1ForwardResultE).
- SrcB  input  32  forwarded rt value (RD2ForwardResultE).
- Busy  output  1  multi-cycle operation in progress (registered).
- Start  output  1  combinational: StartE and op is mult/multu/div/divu and state IDLE.
- HI  output  32  current HI register.
- LO  output  32  current LO register.
- MDUOut  output  32  HI when op is MFHI, LO when op is MFLO, else 0. Combinational; travels to M as ALU-result alternative.

Behaviour:
- Reset (rst low, any time, including mid-operation): state IDLE, counter 0, Busy 0, HI 0, LO 0, pending result discarded.
- FSM states:
  - IDLE -> RUN on accepted multi-cycle Start: latch the computed HI/LO result into shadow registers and load counter with the op's cycle count.
  - RUN: counter decrements each cycle. When counter reaches 1, next edge writes shadow to HI/LO, clears Busy, and returns to IDLE.
- Timing:
  - Busy rises on the edge that accepts Start and stays high for exactly N cycles (N = MULT_CYCLES or DIV_CYCLES).
  - HI/LO are visible updated in the first cycle Busy is low.
- Arithmetic (shadow computed combinationally from SrcA/SrcB at Start):
  - mult: {HI,LO} = signed 64-bit product.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = quotient truncated toward zero; HI = remainder with sign of dividend.
  - divu: unsigned quotient and remainder.
  - div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
  - Divide by zero (div or divu): Busy sequence still runs for DIV_CYCLES; HI/LO are left unchanged at completion.
- Register moves:
  - MTHI/MTLO with StartE in IDLE: HI (or LO) takes SrcA on next edge. Busy stays 0.
  - MTHI/MTLO/MFHI/MFLO while Busy: ignored (writes dropped, MDUOut still reads current HI/LO). The hazard unit guarantees this never occurs architecturally.
- Start of a multi-cycle op while Busy: ignored. Start output is 0, and the in-flight op completes undisturbed.
- Hazard contract: stall D whenever (Start | Busy) and the D-stage instruction is any MDU op.
- No interaction with FlushD; MDU ops are never squashed once in E.

Decomposition:
- Shared package mdu_pkg:
  - Op encodings: MDU_NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8.
  - State encoding: IDLE=0, RUN=1.
  - Default cycle constants.
- ControlUnit imports the same encodings to drive MDUOpE.
- One natural sub-module, mdu_arith: purely combinational 64-bit result generator (op, SrcA, SrcB -> HiRes, LoRes, DivByZero). mdu_ctrl holds the FSM, counter, shadow and HI/LO registers.

Test Plan:
- mult SrcA=0xFFFFFFFE, SrcB=3 -> Busy high exactly 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- multu same operands -> after 5 cycles HI=0x00000002, LO=0xFFFFFFFA.
- div SrcA=0xFFFFFFF9 (-7), SrcB=2 -> Busy 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF. divu 7/0 with prior HI=1, LO=2 -> Busy 10 cycles, HI=1, LO=2 unchanged.
- mthi SrcA=0x12345678, then mfhi next cycle -> Busy stays 0, MDUOut=0x12345678. mtlo during Busy -> LO unchanged.
- Start mult mid-division (cycle 4 of 10) -> Start=0, division completes with its own result at cycle 10.
- rst pulled low at cycle 3 of a mult -> Busy, HI, LO immediately 0; after release, no late HI/LO write occurs.
